// File: rtl/sipo_pkg.sv
// Shared types for the serial-in parallel-out frame receiver.
package sipo_pkg;
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/sipo_shift.sv
// WIDTH-bit MSB-first shift register with parallel output.
module sipo_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], din};
        end
    end
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start/data/stop decode with a one-word output buffer.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             si,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] sr;
    logic            shift;

    assign shift = en && (state == DATA);
    assign busy  = (state != IDLE);

    sipo_shift #(.WIDTH(WIDTH)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .shift (shift),
        .din   (si),
        .q     (sr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (en) begin
                unique case (state)
                    IDLE: begin
                        if (!si) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!si) begin
                            frame_err <= 1'b1;
                        end else if (!valid || ready) begin
                            // Buffer is free or drained on this same edge
                            dout  <= sr;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed testbench for sipo_frame_ctrl at WIDTH=4.
module tb_sipo_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       si = 1'b1;
    logic       ready = 1'b0;
    logic [3:0] dout;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    sipo_frame_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .si        (si),
        .dout      (dout),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic send(input logic b);
        en = 1'b1;
        si = b;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic b);
        en = 1'b0;
        si = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) begin
            send(w[i]);
        end
    endtask

    task automatic drain;
        ready = 1'b1;
        hold(1'b1);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_valid got=%b exp=0", valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        checks++;
        if ({dout, valid, busy, frame_err, overrun} !== 8'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=00000000",
                     {dout, valid, busy, frame_err, overrun});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        ready = 1'b0;
        send(1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b exp=1", busy);
        end
        send_data(4'b1011);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid got=%b exp=0", valid);
        end
        send(1'b1);
        checks++;
        if (valid !== 1'b1 || dout !== 4'b1011 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got=v%b d%b b%b exp=v1 d1011 b0",
                     valid, dout, busy);
        end
        send(1'b1);
        send(1'b1);
        checks++;
        if (valid !== 1'b1 || dout !== 4'b1011) begin
            failures++;
            $display("FAIL basic_held got=v%b d%b exp=v1 d1011", valid, dout);
        end
    endtask

    task automatic test_ready_idle;
        drain();
        ready = 1'b1;
        send(1'b1);
        send(1'b1);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL ready_no_valid got=v%b o%b exp=v0 o0", valid, overrun);
        end
    endtask

    task automatic test_frame_err;
        send(1'b0);
        send_data(4'b1100);
        send(1'b0);
        checks++;
        if (frame_err !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_pulse got=f%b v%b b%b exp=f1 v0 b0",
                     frame_err, valid, busy);
        end
        send(1'b1);
        checks++;
        if (frame_err !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL ferr_clear got=f%b v%b exp=f0 v0", frame_err, valid);
        end
    endtask

    task automatic test_overrun;
        send(1'b0);
        send_data(4'b1011);
        send(1'b1);
        send(1'b0);
        send_data(4'b0110);
        send(1'b1);
        checks++;
        if (overrun !== 1'b1 || dout !== 4'b1011 || valid !== 1'b1) begin
            failures++;
            $display("FAIL ovr_pulse got=o%b d%b v%b exp=o1 d1011 v1",
                     overrun, dout, valid);
        end
        send(1'b1);
        checks++;
        if (overrun !== 1'b0 || dout !== 4'b1011) begin
            failures++;
            $display("FAIL ovr_clear got=o%b d%b exp=o0 d1011", overrun, dout);
        end
    endtask

    task automatic test_back_to_back;
        send(1'b0);
        send_data(4'b0110);
        ready = 1'b1;
        send(1'b1);
        ready = 1'b0;
        checks++;
        if (dout !== 4'b0110 || valid !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b got=d%b v%b o%b exp=d0110 v1 o0",
                     dout, valid, overrun);
        end
    endtask

    task automatic test_en_gap;
        logic [5:0] seq;
        drain();
        seq = 6'b010111;
        for (int i = 5; i >= 0; i--) begin
            send(seq[i]);
            if (i == 0) begin
                checks++;
                if (valid !== 1'b1 || dout !== 4'b1011) begin
                    failures++;
                    $display("FAIL engap_done got=v%b d%b exp=v1 d1011",
                             valid, dout);
                end
            end else begin
                hold(~seq[i]);
                if (i == 1) begin
                    checks++;
                    if (valid !== 1'b0 || busy !== 1'b1) begin
                        failures++;
                        $display("FAIL engap_frozen got=v%b b%b exp=v0 b1",
                                 valid, busy);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        drain();
        send(1'b0);
        send(1'b1);
        send(1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || dout !== 4'b0000) begin
            failures++;
            $display("FAIL async_rst got=b%b d%b exp=b0 d0000", busy, dout);
        end
        rst = 1'b0;
        send(1'b0);
        send_data(4'b1100);
        send(1'b1);
        checks++;
        if (dout !== 4'b1100 || valid !== 1'b1 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got=d%b v%b f%b exp=d1100 v1 f0",
                     dout, valid, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_idle();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_en_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
